// File: rtl/block_ram_arbiter_if.sv
// block_ram_arbiter_if: one client's request/grant bus into the block_ram arbiter
interface block_ram_arbiter_if #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 4
);
  logic                     req;
  logic                     we;
  logic [RAM_ADDR_BITS-1:0] addr;
  logic [RAM_WIDTH-1:0]     wdata;
  logic                     gnt;
  modport master (output req, we, addr, wdata, input gnt);
  modport slave  (input req, we, addr, wdata, output gnt);
endinterface

// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter: two-client round-robin arbiter in front of one block_ram; define RAM_ARB_CLEAR_EN for post-reset zero-fill
module block_ram_arbiter #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  block_ram_arbiter_if.slave       a,
  block_ram_arbiter_if.slave       b,
  output logic                     rd_valid,
  output logic                     rd_id,
  output logic [RAM_WIDTH-1:0]     rd_data,
  output logic                     busy,
  output logic                     ram_w_en,
  output logic [RAM_ADDR_BITS-1:0] ram_w_addr,
  output logic [RAM_ADDR_BITS-1:0] ram_r_addr,
  output logic [RAM_WIDTH-1:0]     ram_in,
  input  logic [RAM_WIDTH-1:0]     ram_out
);
  logic                     run, clr;
  logic [RAM_ADDR_BITS-1:0] clr_addr;
  logic                     last_q, last_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     rd_id_q, rd_id_d;
  logic                     acc, sel_b, sel_we;
  logic [RAM_ADDR_BITS-1:0] sel_addr;
  logic [RAM_WIDTH-1:0]     sel_wdata;
`ifdef RAM_ARB_CLEAR_EN
  // INIT holds busy low during reset and for the release cycle, then CLEAR starts
  typedef enum logic [1:0] {INIT, CLEAR, RUN} state_t;
  state_t                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] cnt_q, cnt_d;
  // state register and clear address counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: step the counter through every address, leave CLEAR when it wraps
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) state_d = CLEAR;
    else if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = RUN;
    end
  end
  // FSM outputs
  always_comb begin
    run      = state_q == RUN;
    clr      = state_q == CLEAR;
    busy     = clr;
    clr_addr = cnt_q;
  end
`else
  assign run      = 1'b1;
  assign clr      = 1'b0;
  assign busy     = 1'b0;
  assign clr_addr = '0;
`endif
  // round-robin: a lone requester wins, on contention the one not served last wins
  assign a.gnt = run & a.req & (~b.req | last_q);
  assign b.gnt = run & b.req & (~a.req | ~last_q);
  // winner mux onto the RAM ports and next-state of the read return path
  always_comb begin
    acc        = a.gnt | b.gnt;
    sel_b      = b.gnt;
    sel_we     = sel_b ? b.we : a.we;
    sel_addr   = sel_b ? b.addr : a.addr;
    sel_wdata  = sel_b ? b.wdata : a.wdata;
    ram_w_en   = clr | (acc & sel_we);
    ram_w_addr = clr ? clr_addr : sel_addr;
    ram_in     = clr ? '0 : sel_wdata;
    ram_r_addr = sel_addr;
    rd_valid_d = acc & ~sel_we;
    rd_id_d    = rd_valid_d ? sel_b : rd_id_q;
    last_d     = acc ? sel_b : last_q;
  end
  // read-return and round-robin history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_id_q    <= 1'b0;
      last_q     <= 1'b1;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_id_q    <= rd_id_d;
      last_q     <= last_d;
    end
  end
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_data  = ram_out;
endmodule
